mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter LAT, default 2: memory read latency in cycles, legal range 1..15.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_req_i  input  1  instruction-fetch request, held until if_ack_o.
REQ-007 SHALL have port if_addr_i  input  AW  fetch address, stable while if_req_i is high.
REQ-008 SHALL have port if_rdata_o  output  DW  fetched instruction, valid with if_ack_o.
REQ-009 SHALL have port if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port dm_req_i  input  1  data-memory request, held until dm_ack_o.
REQ-011 SHALL have port dm_we_i  input  1  data write enable (1 = write, 0 = read).
REQ-012 SHALL have port dm_addr_i  input  AW  data address.
REQ-013 SHALL have port dm_wdata_i  input  DW  write data.
REQ-014 SHALL have port dm_rdata_o  output  DW  read data, valid with dm_ack_o.
REQ-015 SHALL have port dm_ack_o  output  1  one-cycle data completion pulse.
REQ-016 SHALL have port mem_en_o  output  1  shared memory access strobe.
REQ-017 SHALL have port mem_we_o  output  1  shared memory write enable.
REQ-018 SHALL have port mem_addr_o  output  AW  shared memory address.
REQ-019 SHALL have port mem_wdata_o  output  DW  shared memory write data.
REQ-020 SHALL have port mem_rdata_i  input  DW  shared memory read data, valid LAT cycles after mem_en_o.
REQ-021 SHALL have port stall_o  output  1  pipeline freeze request.
REQ-022 SHALL have port busy_o  output  1  high when the FSM is not in IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-024 In IDLE with any request pending, SHALL register the grant, address, we and wdata, then go to ISSUE; with no request pending it SHALL stay in IDLE.
REQ-025 ISSUE SHALL last one cycle, drive mem_en_o=1 with the registered address/we/wdata, load the counter with LAT and go to WAIT.
REQ-026 WAIT SHALL decrement the counter each cycle; when the counter reaches 1 it SHALL capture mem_rdata_i (reads only) and go to DONE.
REQ-027 DONE SHALL pulse the granted requester's ack for exactly one cycle, with rdata_o stable, then go to IDLE.
REQ-028 Request-to-ack latency SHALL be LAT+2 cycles; new arbitration SHALL occur only in IDLE, so back-to-back grants are separated by one IDLE cycle.
REQ-029 On a write, the ack SHALL follow the same timing and the requester's rdata_o SHALL keep its previous value.
REQ-030 When both requests are high in IDLE, dm_req_i SHALL win (fixed priority) unless overridden per REQ-038.
REQ-031 if_ack_o and dm_ack_o SHALL never be high in the same cycle.
REQ-032 stall_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinationally.
REQ-033 A request dropped mid-transaction SHALL NOT abort the access; the ack SHALL still pulse.
REQ-034 mem_en_o SHALL be high only in ISSUE; mem_we_o SHALL be 0 whenever mem_en_o is 0.

Reset
REQ-035 While rst_i=0, SHALL force state IDLE, counter 0, and all outputs 0, independent of the clock.
REQ-036 Reset asserted mid-transaction SHALL discard that transaction; no ack SHALL be issued for it after release.

Configuration
REQ-037 SHALL support macro MEM_ARB_ROUND_ROBIN_EN.
REQ-038 With MEM_ARB_ROUND_ROBIN_EN defined, a tie SHALL be granted to the requester not granted most recently; the last-grant register SHALL reset to IF, so the first tie goes to DM.
REQ-039 Without MEM_ARB_ROUND_ROBIN_EN, fixed DM priority SHALL apply and no last-grant register SHALL exist.

Verification
REQ-040 LAT=2, a lone if_req_i at addr 0x10 with memory returning 0xDEADBEEF -> mem_en_o in cycle 1, if_ack_o in cycle 4 with if_rdata_o=0xDEADBEEF, stall_o low from cycle 4.
REQ-041 dm write to addr 0x40 with data 0x1234 -> mem_en_o=1 and mem_we_o=1 for one cycle, dm_ack_o at LAT+2, dm_rdata_o unchanged.
REQ-042 Simultaneous if_req_i and dm_req_i held high, fixed priority -> DM is served first, IF ack follows 5 cycles after the DM ack (LAT=2), and the acks never overlap.
REQ-043 With MEM_ARB_ROUND_ROBIN_EN and four consecutive ties -> grants are DM, IF, DM, IF.
REQ-044 rst_i pulled low during WAIT -> all outputs 0 immediately; after release there is no ack, and busy_o=0.
REQ-045 if_req_i dropped during WAIT -> if_ack_o still pulses once at LAT+2, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter in front of a single fixed-latency memory.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate tie grants; otherwise data requests win ties.
//
// state | meaning
// IDLE  | arbitrate, latch winner's address/we/wdata
// ISSUE | one-cycle memory strobe, counter loaded with LAT
// WAIT  | count down the read latency, capture data when counter hits 1
// DONE  | one-cycle ack to the granted requester
module mem_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_rdata_o,
   output logic          if_ack_o,
   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic [DW-1:0] dm_rdata_o,
   output logic          dm_ack_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          stall_o,
   output logic          busy_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          gnt_dm_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] if_rdata_q, dm_rdata_q;
   logic          load, capture, pick_dm;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic          last_dm_q;

   // On a tie, the side that did not win last time gets the grant.
   assign pick_dm = dm_req_i & (~if_req_i | ~last_dm_q);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         last_dm_q <= 1'b0;
      else if (load)
         last_dm_q <= pick_dm;
   end
`else
   assign pick_dm = dm_req_i;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req_i | dm_req_i) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 4'(LAT);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               capture = ~we_q;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         gnt_dm_q <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else if (load) begin
         gnt_dm_q <= pick_dm;
         we_q     <= pick_dm & dm_we_i;
         addr_q   <= pick_dm ? dm_addr_i : if_addr_i;
         wdata_q  <= dm_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (capture) begin
         if (gnt_dm_q)
            dm_rdata_q <= mem_rdata_i;
         else
            if_rdata_q <= mem_rdata_i;
      end
   end

   assign mem_en_o    = (state_q == ISSUE);
   assign mem_we_o    = mem_en_o & we_q;
   assign mem_addr_o  = mem_en_o ? addr_q : '0;
   assign mem_wdata_o = mem_en_o ? wdata_q : '0;

   assign if_ack_o   = (state_q == DONE) & ~gnt_dm_q;
   assign dm_ack_o   = (state_q == DONE) & gnt_dm_q;
   assign if_rdata_o = if_rdata_q;
   assign dm_rdata_o = dm_rdata_q;
   assign busy_o     = (state_q != IDLE);

   // Gated by reset so every output reads 0 while reset is held.
   assign stall_o = rst_i & ((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
// The model tracks one outstanding grant and derives strobe/ack/busy/stall timing from it.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          stall;
   logic          busy;

   mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .stall_o(stall), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: one outstanding transaction
   bit            txn;
   int            g_c;
   bit            g_dm, g_we, last_dm;
   logic [31:0]   g_addr, g_wdata, g_rdata;
   logic [31:0]   exp_if_rdata, exp_dm_rdata;

   // memory environment
   logic [31:0]   mem [logic [31:0]];
   int            mem_due = -1;
   logic [31:0]   due_addr;

   // observations
   int            if_ack_n = 0, dm_ack_n = 0, en_n = 0, overlap_n = 0;
   int            if_ack_c, dm_ack_c, en_c;
   bit            en_we;
   bit            if_ack_seen, dm_ack_seen;
   bit            acks[$];

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
   endfunction

   task automatic model_reset();
      txn = 1'b0; last_dm = 1'b0;
      exp_if_rdata = '0; exp_dm_rdata = '0;
      mem_due = -1; if_ack_seen = 1'b0; dm_ack_seen = 1'b0;
   endtask

   task automatic cyc_start();
      @(posedge clk);
      cyc++;
      #1;
      if (if_ack_seen) if_req = 1'b0;
      if (dm_ack_seen) dm_req = 1'b0;
      mem_rdata = (cyc == mem_due) ? mem_rd(due_addr) : $urandom;
   endtask

   task automatic cyc_end();
      bit e_en, e_ia, e_da, e_busy, e_stall, pick;
      @(negedge clk);
      if (!rst) return;
      e_en   = txn && (cyc == g_c + 1);
      e_ia   = txn && (cyc == g_c + LAT + 2) && !g_dm;
      e_da   = txn && (cyc == g_c + LAT + 2) && g_dm;
      e_busy = txn && (cyc > g_c) && (cyc <= g_c + LAT + 2);
      e_stall = (if_req && !e_ia) || (dm_req && !e_da);
      if (txn && (cyc == g_c + LAT + 2) && !g_we) begin
         if (g_dm) exp_dm_rdata = g_rdata;
         else      exp_if_rdata = g_rdata;
      end
      checks++;
      if (if_ack !== e_ia) begin errors++; $display("FAIL if_ack cyc=%0d: got %b expected %b", cyc, if_ack, e_ia); end
      checks++;
      if (dm_ack !== e_da) begin errors++; $display("FAIL dm_ack cyc=%0d: got %b expected %b", cyc, dm_ack, e_da); end
      checks++;
      if ({mem_en, mem_we} !== {e_en, e_en && g_we}) begin
         errors++; $display("FAIL mem_en/we cyc=%0d: got %b%b expected %b%b", cyc, mem_en, mem_we, e_en, e_en && g_we);
      end
      checks++;
      if (busy !== e_busy) begin errors++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, e_busy); end
      checks++;
      if (stall !== e_stall) begin errors++; $display("FAIL stall cyc=%0d: got %b expected %b", cyc, stall, e_stall); end
      checks++;
      if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL if_rdata cyc=%0d: got %h expected %h", cyc, if_rdata, exp_if_rdata); end
      checks++;
      if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL dm_rdata cyc=%0d: got %h expected %h", cyc, dm_rdata, exp_dm_rdata); end
      if (e_en) begin
         checks++;
         if (mem_addr !== g_addr) begin errors++; $display("FAIL mem_addr cyc=%0d: got %h expected %h", cyc, mem_addr, g_addr); end
         if (g_we) begin
            checks++;
            if (mem_wdata !== g_wdata) begin errors++; $display("FAIL mem_wdata cyc=%0d: got %h expected %h", cyc, mem_wdata, g_wdata); end
         end
      end
      // observations
      if (if_ack) begin if_ack_n++; if_ack_c = cyc; acks.push_back(1'b0); end
      if (dm_ack) begin dm_ack_n++; dm_ack_c = cyc; acks.push_back(1'b1); end
      if (if_ack && dm_ack) overlap_n++;
      if_ack_seen = if_ack;
      dm_ack_seen = dm_ack;
      if (mem_en) begin
         en_n++; en_c = cyc; en_we = mem_we;
         mem_due = cyc + LAT; due_addr = mem_addr;
         if (mem_we) mem[mem_addr] = mem_wdata;
      end
      // arbitration happens only when no transaction is outstanding
      if (!txn && (if_req || dm_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         pick = dm_req && (!if_req || !last_dm);
`else
         pick = dm_req;
`endif
         txn = 1'b1; g_c = cyc; g_dm = pick;
         g_addr = pick ? dm_addr : if_addr;
         g_we = pick && dm_we; g_wdata = dm_wdata;
         g_rdata = mem_rd(g_addr);
         last_dm = pick;
      end else if (txn && (cyc == g_c + LAT + 2)) begin
         txn = 1'b0;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin cyc_start(); cyc_end(); end
   endtask

   task automatic test_reset();
      rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h8; dm_addr = 32'hC;
      model_reset();
      #12;
      checks++;
      if ({if_ack, dm_ack, mem_en, mem_we, stall, busy, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         errors++; $display("FAIL reset_outputs: got ack=%b%b en=%b we=%b stall=%b busy=%b expected all 0",
                            if_ack, dm_ack, mem_en, mem_we, stall, busy);
      end
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk); rst = 1'b1;
      step(2);
   endtask

   task automatic test_tie();
      int s, n0, m0;
      n0 = if_ack_n; m0 = dm_ack_n; overlap_n = 0;
      mem[32'h20] = 32'hCAFE_0001; mem[32'h24] = 32'hCAFE_0002;
      cyc_start();
      if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h24;
      s = cyc;
      cyc_end();
      for (int k = 0; k < 20 && (if_ack_n == n0 || dm_ack_n == m0); k++) step(1);
      checks++;
      if (if_ack_n != n0 + 1 || dm_ack_n != m0 + 1) begin
         errors++; $display("FAIL tie_timeout: got if_acks=%0d dm_acks=%0d expected 1 each", if_ack_n - n0, dm_ack_n - m0);
      end else begin
         checks++;
         if (dm_ack_c - s != LAT + 2) begin errors++; $display("FAIL tie_dm_first: got %0d expected %0d", dm_ack_c - s, LAT + 2); end
         checks++;
         if (if_ack_c - dm_ack_c != 5) begin errors++; $display("FAIL tie_if_gap: got %0d expected 5", if_ack_c - dm_ack_c); end
      end
      checks++;
      if (overlap_n != 0) begin errors++; $display("FAIL tie_ack_overlap: got %0d expected 0", overlap_n); end
      step(1);
   endtask

   task automatic test_rr_ties();
      bit exp_seq[4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      acks.delete();
      cyc_start();
      if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h34;
      cyc_end();
      for (int k = 0; k < 60 && acks.size() < 4; k++) begin
         cyc_start();
         if (!if_req) begin if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2; end
         if (!dm_req) begin dm_req = 1'b1; dm_addr = 32'($urandom_range(0, 15)) << 2; end
         cyc_end();
      end
      checks++;
      if (acks.size() < 4) begin
         errors++; $display("FAIL rr_timeout: got %0d acks expected 4", acks.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (acks[i] != exp_seq[i]) begin
               errors++; $display("FAIL tie_grant_%0d: got dm=%b expected dm=%b", i, acks[i], exp_seq[i]);
            end
         end
      end
      cyc_start(); if_req = 1'b0; dm_req = 1'b0; cyc_end();
      step(2);
   endtask

   task automatic test_single_fetch();
      int s, n0, e0;
      n0 = if_ack_n; e0 = en_n;
      mem[32'h10] = 32'hDEAD_BEEF;
      cyc_start();
      if_req = 1'b1; if_addr = 32'h10;
      s = cyc;
      cyc_end();
      for (int k = 0; k < 12 && if_ack_n == n0; k++) step(1);
      checks++;
      if (if_ack_n != n0 + 1) begin
         errors++; $display("FAIL fetch_timeout: got %0d acks expected 1", if_ack_n - n0);
      end else begin
         checks++;
         if (en_c - s != 1 || en_n != e0 + 1) begin errors++; $display("FAIL fetch_strobe: got cycle %0d count %0d expected cycle 1 count 1", en_c - s, en_n - e0); end
         checks++;
         if (if_ack_c - s != 4) begin errors++; $display("FAIL fetch_latency: got %0d expected 4", if_ack_c - s); end
         checks++;
         if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_data: got %h expected deadbeef", if_rdata); end
         checks++;
         if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_at_ack: got %b expected 0", stall); end
      end
      step(2);
   endtask

   task automatic test_dm_write();
      int s, n0, e0;
      logic [31:0] prev;
      prev = exp_dm_rdata;
      n0 = dm_ack_n; e0 = en_n;
      cyc_start();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234;
      s = cyc;
      cyc_end();
      for (int k = 0; k < 12 && dm_ack_n == n0; k++) step(1);
      checks++;
      if (dm_ack_n != n0 + 1) begin
         errors++; $display("FAIL write_timeout: got %0d acks expected 1", dm_ack_n - n0);
      end else begin
         checks++;
         if (en_n != e0 + 1 || en_we !== 1'b1) begin errors++; $display("FAIL write_strobe: got count %0d we %b expected 1 and 1", en_n - e0, en_we); end
         checks++;
         if (dm_ack_c - s != LAT + 2) begin errors++; $display("FAIL write_latency: got %0d expected %0d", dm_ack_c - s, LAT + 2); end
         checks++;
         if (dm_rdata !== prev) begin errors++; $display("FAIL write_rdata_kept: got %h expected %h", dm_rdata, prev); end
      end
      cyc_start(); dm_we = 1'b0; cyc_end();
      // read back the written location
      n0 = dm_ack_n;
      cyc_start(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; cyc_end();
      for (int k = 0; k < 12 && dm_ack_n == n0; k++) step(1);
      checks++;
      if (dm_rdata !== 32'h1234) begin errors++; $display("FAIL write_readback: got %h expected 00001234", dm_rdata); end
      step(2);
   endtask

   task automatic test_drop();
      int s, n0;
      n0 = if_ack_n;
      cyc_start(); if_req = 1'b1; if_addr = 32'h18; s = cyc; cyc_end();
      step(1);
      cyc_start(); if_req = 1'b0; cyc_end();
      step(5);
      checks++;
      if (if_ack_n != n0 + 1) begin
         errors++; $display("FAIL drop_ack_count: got %0d expected 1", if_ack_n - n0);
      end else begin
         checks++;
         if (if_ack_c - s != LAT + 2) begin errors++; $display("FAIL drop_latency: got %0d expected %0d", if_ack_c - s, LAT + 2); end
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int n0;
      n0 = if_ack_n;
      cyc_start(); if_req = 1'b1; if_addr = 32'h1C; cyc_end();
      step(1);
      cyc_start();
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({if_ack, dm_ack, mem_en, mem_we, stall, busy, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         errors++; $display("FAIL midreset_outputs: got ack=%b%b en=%b we=%b stall=%b busy=%b expected all 0",
                            if_ack, dm_ack, mem_en, mem_we, stall, busy);
      end
      if_req = 1'b0; dm_req = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      step(8);
      checks++;
      if (if_ack_n != n0) begin errors++; $display("FAIL midreset_no_ack: got %0d acks expected 0", if_ack_n - n0); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc_start();
         if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if (!dm_req && $urandom_range(0, 3) == 0) begin
            dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
            dm_addr = 32'($urandom_range(0, 15)) << 2; dm_wdata = $urandom;
         end
         cyc_end();
      end
      for (int k = 0; k < 30 && (if_req || dm_req || txn); k++) step(1);
      checks++;
      if (if_req || dm_req || txn) begin errors++; $display("FAIL random_drain: got pending %b%b%b expected 000", if_req, dm_req, txn); end
      checks++;
      if (overlap_n != 0) begin errors++; $display("FAIL random_ack_overlap: got %0d expected 0", overlap_n); end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_rr_ties();
      test_single_fetch();
      test_dm_write();
      test_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
